// File: rtl/otp_access_seq.sv
// Timing sequencer between the register/HIF logic and the eFuse OTP macro.
// Converts byte reads and single-bit program requests into registered macro pin sequences.
module otp_access_seq #(
   parameter int T_SETUP   = 2,
   parameter int T_RD_STRB = 4,
   parameter int T_PG_STRB = 100,
   parameter int T_HOLD    = 2,
   parameter int T_VDDQ    = 10,
   parameter int CNT_W     = 8
) (
   input  logic       xtal_clk,
   input  logic       por_rst,
   input  logic       req,
   input  logic       req_wr,
   input  logic [6:0] req_addr,
   input  logic [2:0] req_bit,
   input  logic       pgm_unlock,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic [7:0] rd_data,
   output logic       o_otp_vddqsw,
   output logic       o_otp_csb,
   output logic       o_otp_strobe,
   output logic       o_otp_load,
   output logic [9:0] o_otp_addr,
   output logic       o_otp_pgenb,
   input  logic [7:0] i_otp_q
);

   localparam logic [CNT_W-1:0] C_SETUP   = CNT_W'(T_SETUP);
   localparam logic [CNT_W-1:0] C_RD_STRB = CNT_W'(T_RD_STRB);
   localparam logic [CNT_W-1:0] C_PG_STRB = CNT_W'(T_PG_STRB);
   localparam logic [CNT_W-1:0] C_HOLD    = CNT_W'(T_HOLD);
   localparam logic [CNT_W-1:0] C_VDDQ    = CNT_W'(T_VDDQ);
   localparam logic [CNT_W-1:0] C_ONE     = CNT_W'(1);

   typedef enum logic [3:0] {
      IDLE, RD_SETUP, RD_STRB, RD_HOLD,
      PG_VON, PG_SETUP, PG_STRB, PG_HOLD, PG_VOFF
   } state_t;

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             w_last;

   // Each state is left on the cycle its entry count has run down to one.
   assign w_last = (r_cnt == C_ONE);

   always_ff @(posedge xtal_clk) begin
      if (por_rst) begin
         r_state      <= IDLE;
         r_cnt        <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
         err          <= 1'b0;
         rd_data      <= 8'h00;
         o_otp_vddqsw <= 1'b0;
         o_otp_csb    <= 1'b1;
         o_otp_strobe <= 1'b0;
         o_otp_load   <= 1'b0;
         o_otp_addr   <= 10'h000;
         o_otp_pgenb  <= 1'b1;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         if (r_state == IDLE) begin
            if (req) begin
               if (req_wr && !pgm_unlock) begin
                  err <= 1'b1;
               end else if (req_wr) begin
                  r_state      <= PG_VON;
                  r_cnt        <= C_VDDQ;
                  o_otp_addr   <= {req_bit, req_addr};
                  o_otp_vddqsw <= 1'b1;
                  busy         <= 1'b1;
               end else begin
                  r_state     <= RD_SETUP;
                  r_cnt       <= C_SETUP;
                  o_otp_addr  <= {3'b000, req_addr};
                  o_otp_csb   <= 1'b0;
                  o_otp_load  <= 1'b1;
                  o_otp_pgenb <= 1'b1;
                  busy        <= 1'b1;
               end
            end
         end else if (!w_last) begin
            r_cnt <= r_cnt - C_ONE;
         end else begin
            case (r_state)
               RD_SETUP: begin
                  r_state      <= RD_STRB;
                  r_cnt        <= C_RD_STRB;
                  o_otp_strobe <= 1'b1;
               end
               RD_STRB: begin
                  r_state      <= RD_HOLD;
                  r_cnt        <= C_HOLD;
                  o_otp_strobe <= 1'b0;
                  rd_data      <= i_otp_q;
               end
               RD_HOLD: begin
                  r_state    <= IDLE;
                  o_otp_csb  <= 1'b1;
                  o_otp_load <= 1'b0;
                  busy       <= 1'b0;
                  done       <= 1'b1;
               end
               // Supply is up before pgenb drops and stays up until pgenb has risen.
               PG_VON: begin
                  r_state     <= PG_SETUP;
                  r_cnt       <= C_SETUP;
                  o_otp_csb   <= 1'b0;
                  o_otp_pgenb <= 1'b0;
                  o_otp_load  <= 1'b0;
               end
               PG_SETUP: begin
                  r_state      <= PG_STRB;
                  r_cnt        <= C_PG_STRB;
                  o_otp_strobe <= 1'b1;
               end
               PG_STRB: begin
                  r_state      <= PG_HOLD;
                  r_cnt        <= C_HOLD;
                  o_otp_strobe <= 1'b0;
               end
               PG_HOLD: begin
                  r_state     <= PG_VOFF;
                  r_cnt       <= C_VDDQ;
                  o_otp_csb   <= 1'b1;
                  o_otp_pgenb <= 1'b1;
               end
               PG_VOFF: begin
                  r_state      <= IDLE;
                  o_otp_vddqsw <= 1'b0;
                  busy         <= 1'b0;
                  done         <= 1'b1;
               end
               default: r_state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_otp_access_seq.sv
// Directed bench for otp_access_seq with a behavioural fuse array and a
// queue-based scoreboard that checks every done/err pulse as it appears.
module tb_otp_access_seq;

   localparam int RD_LAT = 8;    // 2 setup + 4 strobe + 2 hold after the accepting edge
   localparam int PG_LAT = 124;  // 10 + 2 + 100 + 2 + 10

   logic       xtal_clk = 1'b0;
   logic       por_rst  = 1'b1;
   logic       req = 1'b0, req_wr = 1'b0, pgm_unlock = 1'b0;
   logic [6:0] req_addr = 7'h00;
   logic [2:0] req_bit = 3'h0;
   logic       busy, done, err;
   logic [7:0] rd_data;
   logic       o_otp_vddqsw, o_otp_csb, o_otp_strobe, o_otp_load, o_otp_pgenb;
   logic [9:0] o_otp_addr;
   logic [7:0] i_otp_q;

   otp_access_seq dut (
      .xtal_clk(xtal_clk), .por_rst(por_rst), .req(req), .req_wr(req_wr),
      .req_addr(req_addr), .req_bit(req_bit), .pgm_unlock(pgm_unlock),
      .busy(busy), .done(done), .err(err), .rd_data(rd_data),
      .o_otp_vddqsw(o_otp_vddqsw), .o_otp_csb(o_otp_csb), .o_otp_strobe(o_otp_strobe),
      .o_otp_load(o_otp_load), .o_otp_addr(o_otp_addr), .o_otp_pgenb(o_otp_pgenb),
      .i_otp_q(i_otp_q)
   );

   always #5 xtal_clk = ~xtal_clk;

   int total = 0, bad = 0, cyc = 0;
   int done_cnt = 0, busy_cnt = 0, tog = 0, viol = 0;
   int csb_run = 0, stb_run = 0, vdd_run = 0, pgb_run = 0;
   int csb_w = 0, stb_w = 0, vdd_w = 0, pgb_w = 0;
   logic [14:0] prev_pins = '0;

   // Fuse array model: a bit is blown while strobe is high with program enabled.
   logic [7:0] mem [128];
   assign i_otp_q = mem[o_otp_addr[6:0]];
   always @(posedge xtal_clk) begin
      cyc <= cyc + 1;
      if (!o_otp_csb && o_otp_strobe && !o_otp_pgenb && o_otp_vddqsw)
         mem[o_otp_addr[6:0]][o_otp_addr[9:7]] <= 1'b1;
   end

   typedef struct { int kind; int at; logic [7:0] rd; } exp_t;
   exp_t q[$];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Scoreboard monitor plus pin-level observers.
   always @(negedge xtal_clk) begin
      exp_t e;
      logic [14:0] pins;
      pins = {o_otp_csb, o_otp_strobe, o_otp_load, o_otp_pgenb, o_otp_vddqsw, o_otp_addr};
      if (!por_rst) begin
         if (done) done_cnt++;
         if (busy) busy_cnt++;
         if (pins !== prev_pins) tog++;
         if ((!o_otp_pgenb && !o_otp_vddqsw) || (o_otp_strobe && o_otp_csb) ||
             (o_otp_load && !o_otp_pgenb) ||
             (!o_otp_csb && !prev_pins[14] && o_otp_addr !== prev_pins[9:0]))
            viol++;
         if (done || err) begin
            if (q.size() == 0) begin
               total++; bad++;
               $display("FAIL unexpected_resp: done=%0b err=%0b with empty queue (cycle %0d)", done, err, cyc);
            end else begin
               e = q.pop_front();
               check("resp_kind", {30'd0, err, done}, (e.kind == 0) ? 32'd1 : 32'd2);
               check("resp_cycle", cyc, e.at);
               check("resp_rd_data", {24'd0, rd_data}, {24'd0, e.rd});
               check("resp_busy_low", {31'd0, busy}, 32'd0);
            end
         end
      end
      if (!o_otp_csb) csb_run++; else if (csb_run != 0) begin csb_w = csb_run; csb_run = 0; end
      if (o_otp_strobe) stb_run++; else if (stb_run != 0) begin stb_w = stb_run; stb_run = 0; end
      if (o_otp_vddqsw) vdd_run++; else if (vdd_run != 0) begin vdd_w = vdd_run; vdd_run = 0; end
      if (!o_otp_pgenb) pgb_run++; else if (pgb_run != 0) begin pgb_w = pgb_run; pgb_run = 0; end
      prev_pins = pins;
   end

   task automatic issue(input logic wr, input logic [6:0] a, input logic [2:0] b, input logic unl,
                        input logic [7:0] erd, input logic expect_resp, output int acc);
      exp_t e;
      @(negedge xtal_clk);
      req = 1'b1; req_wr = wr; req_addr = a; req_bit = b; pgm_unlock = unl;
      acc = cyc + 1;
      if (expect_resp) begin
         e.kind = (wr && !unl) ? 1 : 0;
         e.at   = (wr && !unl) ? acc : (wr ? acc + PG_LAT : acc + RD_LAT);
         e.rd   = erd;
         q.push_back(e);
      end
      @(negedge xtal_clk);
      req = 1'b0;
   endtask

   task automatic drain(input string nm);
      for (int i = 0; i < 400 && q.size() > 0; i++) @(negedge xtal_clk);
      check(nm, q.size(), 0);
      repeat (3) @(negedge xtal_clk);
   endtask

   initial begin
      int acc, d0, t0, b0;
      exp_t e;
      for (int i = 0; i < 128; i++) mem[i] = 8'h00;
      mem[7'h05] = 8'hA5;
      mem[7'h7F] = 8'h3C;

      // Reset values
      @(negedge xtal_clk);
      check("rst_pins", {17'd0, o_otp_csb, o_otp_strobe, o_otp_load, o_otp_pgenb, o_otp_vddqsw, o_otp_addr},
            {17'd0, 5'b10010, 10'h000});
      check("rst_ctrl", {21'd0, busy, done, err, rd_data}, 32'd0);
      por_rst = 1'b0;
      repeat (2) @(negedge xtal_clk);

      // Read of byte 5
      issue(1'b0, 7'h05, 3'd0, 1'b0, 8'hA5, 1'b1, acc);
      check("rd_busy", {31'd0, busy}, 32'd1);
      drain("rd_drain");
      check("rd_csb_width", csb_w, 8);
      check("rd_strobe_width", stb_w, 4);

      // Program byte 5 bit 3, then read it back (A5 | 08 = AD)
      issue(1'b1, 7'h05, 3'd3, 1'b1, 8'hA5, 1'b1, acc);
      check("pg_addr", {22'd0, o_otp_addr}, 32'h185);
      drain("pg_drain");
      check("pg_vddq_width", vdd_w, PG_LAT);
      check("pg_strobe_width", stb_w, 100);
      check("pg_pgenb_width", pgb_w, 104);
      issue(1'b0, 7'h05, 3'd0, 1'b0, 8'hAD, 1'b1, acc);
      drain("pg_rdback_drain");

      // Locked program request is rejected with no pin activity
      t0 = tog; b0 = busy_cnt;
      issue(1'b1, 7'h06, 3'd1, 1'b0, 8'hAD, 1'b1, acc);
      drain("lock_drain");
      check("lock_pin_toggles", tog - t0, 0);
      check("lock_busy_cycles", busy_cnt - b0, 0);

      // Second request during RD_STRB is ignored
      d0 = done_cnt;
      issue(1'b0, 7'h05, 3'd0, 1'b0, 8'hAD, 1'b1, acc);
      while (cyc < acc + 3) @(negedge xtal_clk);
      req = 1'b1; req_wr = 1'b0; req_addr = 7'h7F;
      @(negedge xtal_clk);
      req = 1'b0;
      drain("ignore_drain");
      repeat (10) @(negedge xtal_clk);
      check("ignore_done_count", done_cnt - d0, 1);

      // Reset on the 50th PG_STRB cycle of a program of byte 7F bit 0
      d0 = done_cnt;
      issue(1'b1, 7'h7F, 3'd0, 1'b1, 8'h00, 1'b0, acc);
      while (cyc < acc + 61) @(negedge xtal_clk);
      check("midrst_in_strobe", {31'd0, o_otp_strobe}, 32'd1);
      por_rst = 1'b1;
      @(negedge xtal_clk);
      check("midrst_pins", {17'd0, o_otp_csb, o_otp_strobe, o_otp_load, o_otp_pgenb, o_otp_vddqsw, o_otp_addr},
            {17'd0, 5'b10010, 10'h000});
      check("midrst_ctrl", {21'd0, busy, done, err, rd_data}, 32'd0);
      por_rst = 1'b0;
      repeat (140) @(negedge xtal_clk);
      check("midrst_no_done", done_cnt - d0, 0);
      issue(1'b0, 7'h05, 3'd0, 1'b0, 8'hAD, 1'b1, acc);
      drain("midrst_read_drain");

      // req held high: repeated reads of 7F (3C with bit 0 already blown = 3D)
      d0 = done_cnt;
      @(negedge xtal_clk);
      req = 1'b1; req_wr = 1'b0; req_addr = 7'h7F;
      acc = cyc + 1;
      for (int i = 0; i < 3; i++) begin
         e.kind = 0; e.at = acc + RD_LAT + 9 * i; e.rd = 8'h3D;
         q.push_back(e);
      end
      while (cyc < acc + 18) @(negedge xtal_clk);
      req = 1'b0;
      drain("held_drain");
      check("held_done_count", done_cnt - d0, 3);
      check("held_addr", {22'd0, o_otp_addr}, 32'h07F);

      check("pin_order_violations", viol, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
